par_to_ser_stream: RTL and testbench
====================================

Name: par_to_ser_stream

Overview:
- Parametrised successor to the single-lane parallel-to-serial converter.
- Captures a vector of up to Length words in one load handshake, then streams them out Lanes words per beat under a valid/ready handshake.
- Supports a programmable word count, a partial final beat marked by a lane mask, and back-to-back loads with no idle cycle.
- Sits between wide compute stages (layer output buffers) and narrow serial consumers.

Parameters:
- N, 8, width of one data word
- Length, 3, maximum number of words per load (>=1)
- Lanes, 1, words emitted per output beat (1..Length)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- load_valid_i  in  1  load request
- load_ready_o  out  1  block can accept a load this cycle
- store_i  in  N x [Length-1:0] (unpacked)  words to capture on the load handshake
- count_i  in  $clog2(Length+1)  number of words to emit for this load, sampled on the load handshake
- valid_o  out  1  output beat valid
- ready_i  in  1  consumer accepts the beat
- data_o  out  N x [Lanes-1:0] (unpacked)  output words; lane k = word (position+k)
- lane_valid_o  out  Lanes  per-lane valid mask for the current beat
- last_o  out  1  current beat is the final beat of the load
- done_o  out  1  one-cycle pulse the cycle after the final beat handshake

Behaviour:
- Reset (rst_i high at a clock edge, synchronous):
  - state = IDLE; store, position and latched count cleared to 0.
  - valid_o=0, done_o=0, last_o=0, lane_valid_o=0, data_o all 0.
  - load_ready_o=1 from the first cycle after reset.
  - Reset overrides every other input, including mid-stream; any in-flight beats are discarded and no done_o pulse is produced.
- States: IDLE, SHIFT.
- Load handshake = load_valid_i & load_ready_o.
  - load_ready_o = (state==IDLE) | (valid_o & ready_i & last_o). This term is combinational and allows back-to-back loads.
- Load handshake actions:
  - store[i] <= store_i[i] for all i; position <= 0.
  - cnt <= min(count_i, Length). Counts above Length are clamped.
  - If cnt != 0: state <= SHIFT.
  - If cnt == 0: state stays or returns to IDLE, no beats are emitted, and done_o pulses on the next cycle.
- Latency: load handshake at edge T gives valid_o=1 with the first beat from T+1.
- SHIFT state:
  - valid_o=1.
  - lane_valid_o[k] = (position+k < cnt).
  - data_o[k] = store[position+k] when lane k is valid, otherwise 0.
  - last_o = (position+Lanes >= cnt).
- Beat handshake = valid_o & ready_i.
  - Not last beat: position <= position+Lanes.
  - Last beat, with a simultaneous load: new load captured, stays in SHIFT (or goes to IDLE if the new cnt==0).
  - Last beat, no load: state <= IDLE.
- Stall: while valid_o & !ready_i, data_o, lane_valid_o and last_o hold stable and position does not change.
- Beats per load = ceil(cnt/Lanes). The final beat is partial when cnt mod Lanes != 0.
- done_o is registered and pulses for exactly one cycle after each final beat handshake, or after a cnt==0 load. Back-to-back loads give one pulse per load.
- Width rule: position is wide enough to hold Length+Lanes without overflow. Index comparisons are unsigned.
- load_valid_i while load_ready_o=0 is ignored. store_i and count_i are don't-care outside the load handshake.

Optional Feature:
- Macro: P2S_REVERSE_EN.
- When defined, words are emitted in descending index order. Lane k of a beat = store[cnt-1-(position+k)], so the first beat starts at word cnt-1. The lane mask and last_o rules are unchanged.
- When undefined, words are emitted in ascending order (store[0] first) as described above.

Test Plan (N=8, Length=5, Lanes=2 unless noted):
- Reset then idle: rst_i 1 for 2 cycles -> valid_o=0, done_o=0, data_o={0,0}, load_ready_o=1 on the cycle after reset is released.
- Full load: store_i={0x10,0x11,0x12,0x13,0x14}, count_i=5, ready_i=1 -> beats {10,11} mask 11, {12,13} mask 11, {14,00} mask 01 with last_o=1; done_o pulses 1 cycle later.
- Backpressure: same load with ready_i toggling 1,0,0,1,1 -> each beat holds while ready_i=0; the 3-beat sequence is unchanged; a single done_o pulse.
- Zero and clamped count: count_i=0 -> no valid_o, done_o pulses at T+1. count_i=7 -> behaves as count 5 (3 beats).
- Back-to-back: second load presented during the last beat of the first (count_i=3, store_i={0x20,0x21,0x22}) -> accepted that cycle; next beats {20,21}, {22,00}; two done_o pulses.
- Reset mid-stream: rst_i asserted after the first beat -> valid_o=0 next cycle, no done_o, load_ready_o=1. With P2S_REVERSE_EN and the full load: beats {14,13}, {12,11}, {10,00}.

Source files
------------

// File: rtl/par_to_ser_stream_if.sv
// Load and output-beat handshake bundle for par_to_ser_stream.
// The slave modport is the converter's view; the master modport is the producer/consumer side.
interface par_to_ser_stream_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned Length = 3,
  parameter int unsigned Lanes  = 1
);
  localparam int unsigned CntW = $clog2(Length + 1);

  logic            load_valid_i;
  logic            load_ready_o;
  logic [N-1:0]    store_i [Length-1:0];
  logic [CntW-1:0] count_i;
  logic            valid_o;
  logic            ready_i;
  logic [N-1:0]    data_o [Lanes-1:0];
  logic [Lanes-1:0] lane_valid_o;
  logic            last_o;
  logic            done_o;

  modport master (
    output load_valid_i, store_i, count_i, ready_i,
    input  load_ready_o, valid_o, data_o, lane_valid_o, last_o, done_o
  );

  modport slave (
    input  load_valid_i, store_i, count_i, ready_i,
    output load_ready_o, valid_o, data_o, lane_valid_o, last_o, done_o
  );
endinterface

// File: rtl/par_to_ser_stream.sv
// Captures up to Length words per load and streams them Lanes words per beat.
// Define P2S_REVERSE_EN to emit words in descending index order.
module par_to_ser_stream #(
  parameter int unsigned N      = 8,
  parameter int unsigned Length = 3,
  parameter int unsigned Lanes  = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  par_to_ser_stream_if.slave  bus
);
  localparam int unsigned CntW = $clog2(Length + 1);
  localparam int unsigned PosW = $clog2(Length + Lanes + 1);
  localparam int unsigned IdxW = (Length > 1) ? $clog2(Length) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]      state_q;
  logic [N-1:0]    store_q [Length-1:0];
  logic [PosW-1:0] pos_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;

  logic            shifting;
  logic            last;
  logic            load_ready;
  logic            load_hs;
  logic            beat_hs;
  logic [CntW-1:0] cnt_clamped;
  logic [PosW-1:0] lane_pos [Lanes-1:0];
  logic [PosW-1:0] word_idx [Lanes-1:0];
  logic [Lanes-1:0] lane_valid;

  always_comb begin
    shifting    = (state_q == StShift);
    last        = shifting && ((pos_q + PosW'(Lanes)) >= PosW'(cnt_q));
    // Ready also during the final beat handshake so loads can run back-to-back.
    load_ready  = !shifting || (bus.ready_i && last);
    load_hs     = bus.load_valid_i && load_ready;
    beat_hs     = shifting && bus.ready_i;
    cnt_clamped = (bus.count_i > CntW'(Length)) ? CntW'(Length) : bus.count_i;
  end

  always_comb begin
    for (int k = 0; k < Lanes; k++) begin
      lane_pos[k]   = pos_q + PosW'(k);
      lane_valid[k] = shifting && (lane_pos[k] < PosW'(cnt_q));
`ifdef P2S_REVERSE_EN
      word_idx[k]   = PosW'(cnt_q) - PosW'(1) - lane_pos[k];
`else
      word_idx[k]   = lane_pos[k];
`endif
      bus.data_o[k] = lane_valid[k] ? store_q[IdxW'(word_idx[k])] : '0;
    end
  end

  assign bus.load_ready_o = load_ready;
  assign bus.valid_o      = shifting;
  assign bus.lane_valid_o = lane_valid;
  assign bus.last_o       = last;
  assign bus.done_o       = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pos_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < Length; i++) store_q[i] <= '0;
    end else begin
      done_q <= (beat_hs && last) || (load_hs && (cnt_clamped == '0));
      if (load_hs) begin
        for (int i = 0; i < Length; i++) store_q[i] <= bus.store_i[i];
        pos_q   <= '0;
        cnt_q   <= cnt_clamped;
        state_q <= (cnt_clamped != '0) ? StShift : StIdle;
      end else if (beat_hs) begin
        if (last) state_q <= StIdle;
        else      pos_q   <= pos_q + PosW'(Lanes);
      end
    end
  end
endmodule

// File: tb/tb_par_to_ser_stream.sv
// Bench for par_to_ser_stream: directed cycle table, hand sequences and a randomized
// run against a queue-of-beats reference model.
module tb_par_to_ser_stream;
  localparam int unsigned N      = 8;
  localparam int unsigned Length = 5;
  localparam int unsigned Lanes  = 2;
  localparam int unsigned CntW   = $clog2(Length + 1);
`ifdef P2S_REVERSE_EN
  localparam bit Rev = 1'b1;
`else
  localparam bit Rev = 1'b0;
`endif

  typedef struct packed {
    logic                      valid;
    logic                      lr;
    logic                      last;
    logic                      done;
    logic [Lanes-1:0]          mask;
    logic [Lanes-1:0][N-1:0]   data;
  } obs_t;

  typedef struct packed {
    logic [Lanes-1:0]          mask;
    logic [Lanes-1:0][N-1:0]   data;
    logic                      last;
  } beat_t;

  // All int so table literals need no width casts; p0/p1 = forward word position or -1.
  typedef struct {
    int lv; int cnt; int rdy;
    int v;  int lr;  int last; int done; int p0; int p1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  par_to_ser_stream_if #(.N(N), .Length(Length), .Lanes(Lanes)) bus ();

  par_to_ser_stream #(.N(N), .Length(Length), .Lanes(Lanes)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  vec_t tab[$];
  beat_t mq[$];
  logic [N-1:0] sw [Length];

  function automatic obs_t sample();
    obs_t o;
    o.valid = bus.valid_o;
    o.lr    = bus.load_ready_o;
    o.last  = bus.last_o;
    o.done  = bus.done_o;
    o.mask  = bus.lane_valid_o;
    for (int k = 0; k < Lanes; k++) o.data[k] = bus.data_o[k];
    return o;
  endfunction

  function automatic obs_t mk(int v, int lr, int last, int done, int p0, int p1, int base,
                              int cnt);
    obs_t o;
    int p;
    o       = '0;
    o.valid = (v != 0);
    o.lr    = (lr != 0);
    o.last  = (last != 0);
    o.done  = (done != 0);
    for (int k = 0; k < Lanes; k++) begin
      p = (k == 0) ? p0 : p1;
      if (p >= 0) begin
        o.mask[k] = 1'b1;
        o.data[k] = N'(Rev ? (base + cnt - 1 - p) : (base + p));
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b lr=%b last=%b done=%b mask=%b data=%h, want v=%b lr=%b last=%b done=%b mask=%b data=%h",
               name, act.valid, act.lr, act.last, act.done, act.mask, act.data,
               exp.valid, exp.lr, exp.last, exp.done, exp.mask, exp.data);
    end
  endtask

  task automatic drive(input int lv, input int cnt, input int base, input int rdy);
    bus.load_valid_i = (lv != 0);
    bus.count_i      = CntW'(cnt);
    bus.ready_i      = (rdy != 0);
    for (int i = 0; i < Length; i++) bus.store_i[i] = N'(base + i);
  endtask

  task automatic add(input int lv, input int cnt, input int rdy, input int v, input int lr,
                     input int last, input int done, input int p0, input int p1);
    vec_t r;
    r = '{lv, cnt, rdy, v, lr, last, done, p0, p1};
    tab.push_back(r);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    obs_t  eo;
    beat_t b;
    bit    m_valid, m_lr, lv, rdy, exp_done, nd;
    int    cnt, eff;
    logic [N-1:0] w [Length];

    // Full load
    add(1, 5, 1, 0, 1, 0, 0, -1, -1);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1);
    add(0, 0, 1, 1, 0, 0, 0,  2,  3);
    add(0, 0, 1, 1, 1, 1, 0,  4, -1);
    add(0, 0, 1, 0, 1, 0, 1, -1, -1);
    add(0, 0, 1, 0, 1, 0, 0, -1, -1);
    // Backpressure, ready 1,0,0,1,1
    add(1, 5, 0, 0, 1, 0, 0, -1, -1);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1);
    add(0, 0, 0, 1, 0, 0, 0,  2,  3);
    add(0, 0, 0, 1, 0, 0, 0,  2,  3);
    add(0, 0, 1, 1, 0, 0, 0,  2,  3);
    add(0, 0, 1, 1, 1, 1, 0,  4, -1);
    add(0, 0, 1, 0, 1, 0, 1, -1, -1);
    add(0, 0, 0, 0, 1, 0, 0, -1, -1);
    // Zero count
    add(1, 0, 1, 0, 1, 0, 0, -1, -1);
    add(0, 0, 1, 0, 1, 0, 1, -1, -1);
    add(0, 0, 1, 0, 1, 0, 0, -1, -1);
    // Clamped count 7 -> 5
    add(1, 7, 1, 0, 1, 0, 0, -1, -1);
    add(0, 0, 1, 1, 0, 0, 0,  0,  1);
    add(0, 0, 1, 1, 0, 0, 0,  2,  3);
    add(0, 0, 1, 1, 1, 1, 0,  4, -1);
    add(0, 0, 1, 0, 1, 0, 1, -1, -1);

    rst = 1'b1;
    drive(0, 0, 0, 0);
    step();
    check("reset", mk(0, 1, 0, 0, -1, -1, 0, 0));
    step();
    rst = 1'b0;
    #1;
    check("post_reset", mk(0, 1, 0, 0, -1, -1, 0, 0));
    step();

    foreach (tab[i]) begin
      drive(tab[i].lv, tab[i].cnt, 8'h10, tab[i].rdy);
      #1;
      check($sformatf("vec%0d", i), mk(tab[i].v, tab[i].lr, tab[i].last, tab[i].done,
                                        tab[i].p0, tab[i].p1, 8'h10, 5));
      step();
    end

    // Back-to-back: second load during the final beat of the first
    drive(1, 5, 8'h10, 1);
    #1;
    check("b2b_load1", mk(0, 1, 0, 0, -1, -1, 0, 0));
    step();
    drive(0, 0, 8'h10, 1);
    #1;
    check("b2b_beat0", mk(1, 0, 0, 0, 0, 1, 8'h10, 5));
    step();
    check("b2b_beat1", mk(1, 0, 0, 0, 2, 3, 8'h10, 5));
    step();
    drive(1, 3, 8'h20, 1);
    #1;
    check("b2b_accept", mk(1, 1, 1, 0, 4, -1, 8'h10, 5));
    step();
    drive(0, 0, 8'h20, 1);
    #1;
    check("b2b_l2beat0", mk(1, 0, 0, 1, 0, 1, 8'h20, 3));
    step();
    check("b2b_l2beat1", mk(1, 1, 1, 0, 2, -1, 8'h20, 3));
    step();
    check("b2b_done2", mk(0, 1, 0, 1, -1, -1, 0, 0));
    step();
    check("b2b_quiet", mk(0, 1, 0, 0, -1, -1, 0, 0));

    // Reset mid-stream
    drive(1, 5, 8'h10, 1);
    step();
    drive(0, 0, 8'h10, 1);
    #1;
    check("rst_mid_beat0", mk(1, 0, 0, 0, 0, 1, 8'h10, 5));
    step();
    rst = 1'b1;
    step();
    check("rst_mid_idle", mk(0, 1, 0, 0, -1, -1, 0, 0));
    rst = 1'b0;
    step();
    check("rst_mid_nodone", mk(0, 1, 0, 0, -1, -1, 0, 0));

    // Randomized run against the beat-queue model
    rst = 1'b1;
    drive(0, 0, 0, 0);
    step();
    rst = 1'b0;
    mq.delete();
    exp_done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      lv  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cnt = int'($urandom_range(0, 7));
      bus.load_valid_i = lv;
      bus.ready_i      = rdy;
      bus.count_i      = CntW'(cnt);
      for (int i = 0; i < Length; i++) begin
        sw[i] = N'($urandom);
        bus.store_i[i] = sw[i];
      end
      #1;
      m_valid = (mq.size() != 0);
      b       = m_valid ? mq[0] : '0;
      m_lr    = !m_valid || (rdy && b.last);
      eo       = '0;
      eo.valid = m_valid;
      eo.lr    = m_lr;
      eo.last  = b.last;
      eo.done  = exp_done;
      eo.mask  = b.mask;
      eo.data  = b.data;
      check($sformatf("rand%0d", c), eo);

      eff = (cnt > int'(Length)) ? int'(Length) : cnt;
      nd  = (m_valid && rdy && b.last) || (lv && m_lr && eff == 0);
      if (m_valid && rdy) void'(mq.pop_front());
      if (lv && m_lr && eff > 0) begin
        for (int j = 0; j < eff; j++) w[j] = Rev ? sw[eff - 1 - j] : sw[j];
        for (int s = 0; s < eff; s += Lanes) begin
          b = '0;
          for (int k = 0; k < Lanes; k++) begin
            if (s + k < eff) begin
              b.mask[k] = 1'b1;
              b.data[k] = w[s + k];
            end
          end
          b.last = (s + Lanes >= eff);
          mq.push_back(b);
        end
      end
      exp_done = nd;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
